// File: rtl/halt_monitor.sv
// Retirement-side halt detector: spots the halt encoding on writeback, drains the
// pipeline for a fixed interval, waits for the store buffer to empty, then raises isHalt.
module halt_monitor #(
    parameter logic [31:0] HALT_INSTR   = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wbValid,
    input  logic [31:0]        wbInstr,
    input  logic [31:0]        wbPc,
    input  logic               storeBufEmpty,
    output logic               isHalt,
    output logic [31:0]        haltPc,
    output logic [COUNT_W-1:0] retiredCount,
    output logic               postHaltRetire
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

    state_t     state;
    state_t     stateNext;
    logic [7:0] drainCnt;
    logic [7:0] drainCntNext;
    logic       haltRetire;

    // Only the first halt seen in RUN counts; later halt encodings are just stray retirements.
    assign haltRetire = (state == RUN) && wbValid && (wbInstr == HALT_INSTR);

    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        case (state)
            RUN: begin
                if (haltRetire) begin
                    stateNext    = DRAIN;
                    drainCntNext = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (drainCnt != 8'd0) begin
                    drainCntNext = drainCnt - 8'd1;
                end else if (storeBufEmpty) begin
                    stateNext = HALTED;
                end
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // isHalt is registered off the next state so it rises on the same edge HALTED is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            drainCnt       <= 8'd0;
            isHalt         <= 1'b0;
            haltPc         <= 32'd0;
            retiredCount   <= '0;
            postHaltRetire <= 1'b0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
            isHalt   <= (stateNext == HALTED);
            if ((state == RUN) && wbValid) begin
                retiredCount <= retiredCount + COUNT_W'(1);
            end
            if (haltRetire) begin
                haltPc <= wbPc;
            end
            if ((state != RUN) && wbValid) begin
                postHaltRetire <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_halt_monitor.sv
// Bench for halt_monitor: DUT A (D=4, 32-bit count) and DUT B (D=0, 4-bit count)
// share one stimulus stream; expectations are queued at drive time and checked after the edge.
module tb_halt_monitor;

    localparam logic [31:0] HALT = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbValid;
    logic [31:0] wbInstr;
    logic [31:0] wbPc;
    logic        sbe;

    logic        isHaltA, postA;
    logic [31:0] haltPcA, cntA;
    logic        isHaltB, postB;
    logic [31:0] haltPcB;
    logic [3:0]  cntB;

    always #5 clk = ~clk;

    halt_monitor #(.HALT_INSTR(HALT), .DRAIN_CYCLES(4), .COUNT_W(32)) dutA (
        .clk(clk), .reset(reset), .wbValid(wbValid), .wbInstr(wbInstr), .wbPc(wbPc),
        .storeBufEmpty(sbe), .isHalt(isHaltA), .haltPc(haltPcA), .retiredCount(cntA),
        .postHaltRetire(postA)
    );

    halt_monitor #(.HALT_INSTR(HALT), .DRAIN_CYCLES(0), .COUNT_W(4)) dutB (
        .clk(clk), .reset(reset), .wbValid(wbValid), .wbInstr(wbInstr), .wbPc(wbPc),
        .storeBufEmpty(sbe), .isHalt(isHaltB), .haltPc(haltPcB), .retiredCount(cntB),
        .postHaltRetire(postB)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        sbe;
        logic        isHalt;
        logic [31:0] cnt;
        logic [31:0] hpc;
        logic        post;
    } vec_t;

    vec_t q[$];
    vec_t tbl[13];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic s, input logic ih, input logic [31:0] cnt,
                                input logic [31:0] hpc, input logic post);
        vec_t t;
        t.v = v; t.instr = instr; t.pc = pc; t.sbe = s;
        t.isHalt = ih; t.cnt = cnt; t.hpc = hpc; t.post = post;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input bit selB, input string tag, input vec_t e);
        if (selB) begin
            chk({tag, ".isHalt"}, {31'b0, isHaltB}, {31'b0, e.isHalt});
            chk({tag, ".count"},  {28'b0, cntB},    e.cnt);
            chk({tag, ".haltPc"}, haltPcB,          e.hpc);
            chk({tag, ".post"},   {31'b0, postB},   {31'b0, e.post});
        end else begin
            chk({tag, ".isHalt"}, {31'b0, isHaltA}, {31'b0, e.isHalt});
            chk({tag, ".count"},  cntA,             e.cnt);
            chk({tag, ".haltPc"}, haltPcA,          e.hpc);
            chk({tag, ".post"},   {31'b0, postA},   {31'b0, e.post});
        end
    endtask

    task automatic cyc(input bit selB, input string tag, input vec_t t);
        vec_t e;
        @(negedge clk);
        wbValid = t.v;
        wbInstr = t.instr;
        wbPc    = t.pc;
        sbe     = t.sbe;
        q.push_back(t);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk_outs(selB, tag, e);
    endtask

    task automatic do_reset(input bit selB, input string tag);
        @(negedge clk);
        reset   = 1'b1;
        wbValid = 1'b0;
        wbInstr = NOP;
        wbPc    = 32'd0;
        sbe     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outs(selB, tag, mk(0, NOP, 0, 1, 0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b1; wbValid = 1'b0; wbInstr = NOP; wbPc = 32'd0; sbe = 1'b1;

        // Five retirements, idle, halt at 0x40, then drain with empty store buffer.
        for (int i = 0; i < 5; i++) tbl[i] = mk(1, NOP, 32'(i * 4), 1, 0, 32'(i + 1), 0, 0);
        tbl[5] = mk(0, NOP, 0, 1, 0, 5, 0, 0);
        tbl[6] = mk(1, HALT, 32'h40, 1, 0, 6, 32'h40, 0);
        for (int i = 7; i < 11; i++) tbl[i] = mk(0, NOP, 0, 1, 0, 6, 32'h40, 0);
        tbl[11] = mk(0, NOP, 0, 1, 1, 6, 32'h40, 0);
        tbl[12] = mk(0, NOP, 0, 0, 1, 6, 32'h40, 0);

        do_reset(0, "rstA");
        for (int i = 0; i < 13; i++) cyc(0, $sformatf("basic%0d", i), tbl[i]);

        // Store buffer busy until well after the drain counter expires.
        do_reset(0, "rst2");
        cyc(0, "sb.halt", mk(1, HALT, 32'h40, 0, 0, 1, 32'h40, 0));
        for (int i = 0; i < 9; i++) cyc(0, $sformatf("sb.wait%0d", i), mk(0, NOP, 0, 0, 0, 1, 32'h40, 0));
        cyc(0, "sb.empty", mk(0, NOP, 0, 1, 1, 1, 32'h40, 0));
        cyc(0, "sb.sticky", mk(0, NOP, 0, 0, 1, 1, 32'h40, 0));

        // Retirements after halt: error flag only, count/PC frozen, halt timing unchanged.
        do_reset(0, "rst3");
        cyc(0, "ph.halt", mk(1, HALT, 32'h40, 1, 0, 1, 32'h40, 0));
        cyc(0, "ph.idle", mk(0, NOP, 0, 1, 0, 1, 32'h40, 0));
        cyc(0, "ph.stray", mk(1, NOP, 32'h99, 1, 0, 1, 32'h40, 1));
        cyc(0, "ph.halt2", mk(1, HALT, 32'h55, 1, 0, 1, 32'h40, 1));
        cyc(0, "ph.d1", mk(0, NOP, 0, 1, 0, 1, 32'h40, 1));
        cyc(0, "ph.done", mk(0, NOP, 0, 1, 1, 1, 32'h40, 1));

        // Asynchronous reset mid-drain, then a clean halt at 0x80.
        do_reset(0, "rst4");
        cyc(0, "ar.halt", mk(1, HALT, 32'h40, 1, 0, 1, 32'h40, 0));
        cyc(0, "ar.idle", mk(0, NOP, 0, 1, 0, 1, 32'h40, 0));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_outs(0, "ar.async", mk(0, NOP, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        cyc(0, "ar.halt80", mk(1, HALT, 32'h80, 1, 0, 1, 32'h80, 0));
        for (int i = 0; i < 4; i++) cyc(0, $sformatf("ar.d%0d", i), mk(0, NOP, 0, 1, 0, 1, 32'h80, 0));
        cyc(0, "ar.done", mk(0, NOP, 0, 1, 1, 1, 32'h80, 0));

        // DUT B: 4-bit count wraps after 16; zero drain halts one edge after retirement.
        do_reset(1, "rstB");
        for (int i = 0; i < 17; i++)
            cyc(1, $sformatf("wrap%0d", i), mk(1, NOP, 32'(i * 4), 1, 0, 32'((i + 1) % 16), 0, 0));
        cyc(1, "d0.halt", mk(1, HALT, 32'h30, 1, 0, 2, 32'h30, 0));
        cyc(1, "d0.done", mk(0, NOP, 0, 1, 1, 2, 32'h30, 0));
        cyc(1, "d0.hold", mk(0, NOP, 0, 0, 1, 2, 32'h30, 0));

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
